// File: rtl/dcache_pkg.sv
// Shared types, field widths and address slicing for the direct-mapped data cache.
// The field widths describe a 32-bit byte address: 25-bit tag, 3-bit index, 2-bit word offset, 2-bit byte offset.
package dcache_pkg;

  localparam int INDEX_BITS  = 3;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int BLOCK_BITS  = 128;
  localparam int LINES       = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    REFILL
  } state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] addr);
    return addr[31 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] addr);
    return addr[OFFSET_BITS+2 +: INDEX_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] addr);
    return addr[2 +: OFFSET_BITS];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage (valid/dirty/tag/data): combinational read of one line, synchronous write.
// A block refill takes priority over a word write; reset clears valid and dirty only.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  index,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [BLOCK_BITS-1:0]  rd_data,
  input  logic                   word_we,
  input  logic [OFFSET_BITS-1:0] word_offset,
  input  logic [31:0]            word_data,
  input  logic                   refill_we,
  input  logic [TAG_BITS-1:0]    refill_tag,
  input  logic [BLOCK_BITS-1:0]  refill_data
);

  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [TAG_BITS-1:0]   tag_d  [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];
  logic [BLOCK_BITS-1:0] data_d [LINES];

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (refill_we) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
      tag_d[index]   = refill_tag;
      data_d[index]  = refill_data;
    end else if (word_we) begin
      dirty_d[index] = 1'b1;
      data_d[index][{word_offset, 5'd0} +: 32] = word_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache.sv
// Write-back, write-allocate direct-mapped cache: hits complete in-cycle; a miss stalls via BUSYWAIT
// for detect + optional write-back + fetch + refill, each memory phase ending on the first MEM_BUSYWAIT-low cycle.
module dcache
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         READ,
  input  logic         WRITE,
  input  logic [31:0]  ADDRESS,
  input  logic [31:0]  WRITE_DATA,
  output logic [31:0]  READ_DATA,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  state_e                state_q, state_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [BLOCK_BITS-1:0] fill_q, fill_d;
  logic [31:0]           miss_addr_q, miss_addr_d;

  logic [31:0]           cur_addr;
  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [OFFSET_BITS-1:0] req_offset;
  logic                  rd_valid, rd_dirty, hit, req, word_we, refill_we;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [BLOCK_BITS-1:0] rd_data;

  // The latched miss address keeps the fill on track even if the CPU drops its request.
  assign cur_addr   = (state_q == IDLE) ? ADDRESS : miss_addr_q;
  assign req_tag    = addr_tag(cur_addr);
  assign req_index  = addr_index(cur_addr);
  assign req_offset = addr_offset(ADDRESS);

  dcache_array u_array (
    .clk         (CLK),
    .rst         (RESET),
    .index       (req_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_data     (rd_data),
    .word_we     (word_we),
    .word_offset (req_offset),
    .word_data   (WRITE_DATA),
    .refill_we   (refill_we),
    .refill_tag  (req_tag),
    .refill_data (fill_q)
  );

  assign req       = READ || WRITE;
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign word_we   = (state_q == IDLE) && WRITE && hit;
  assign refill_we = (state_q == REFILL);

  assign BUSYWAIT      = (state_q != IDLE) || (req && !hit);
  assign READ_DATA     = rd_data[{req_offset, 5'd0} +: 32];
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = (state_q == WRITEBACK) ? {rd_tag, req_index} : miss_addr_q[31:4];
  assign MEM_WRITEDATA = rd_data;

  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    fill_d      = fill_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          miss_addr_d = ADDRESS;
          if (rd_valid && rd_dirty) begin
            state_d     = WRITEBACK;
            mem_write_d = 1'b1;
          end else begin
            state_d    = FETCH;
            mem_read_d = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_d     = FETCH;
          mem_write_d = 1'b0;
          mem_read_d  = 1'b1;
        end
      end
      FETCH: begin
        if (!MEM_BUSYWAIT) begin
          state_d    = REFILL;
          mem_read_d = 1'b0;
          fill_d     = MEM_READDATA;
        end
      end
      REFILL:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
    fill_q      <= fill_d;
    miss_addr_q <= miss_addr_d;
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: hit vectors from a table, miss/eviction/reset sequences by hand.
// Main memory model completes each block transfer after 4 busy cycles.
module tb_dcache;

  logic         CLK = 1'b0;
  logic         RESET, READ, WRITE;
  logic [31:0]  ADDRESS, WRITE_DATA, READ_DATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;

  int checks = 0;
  int errors = 0;

  dcache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .READ          (READ),
    .WRITE         (WRITE),
    .ADDRESS       (ADDRESS),
    .WRITE_DATA    (WRITE_DATA),
    .READ_DATA     (READ_DATA),
    .BUSYWAIT      (BUSYWAIT),
    .MEM_READ      (MEM_READ),
    .MEM_WRITE     (MEM_WRITE),
    .MEM_ADDRESS   (MEM_ADDRESS),
    .MEM_WRITEDATA (MEM_WRITEDATA),
    .MEM_READDATA  (MEM_READDATA),
    .MEM_BUSYWAIT  (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [127:0] blk(input int i);
    logic [31:0] base;
    if (i == 1) return 128'h44444444_33333333_22222222_11111111;
    base = 32'hB000_0000 + (32'(i) << 8);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Memory model: busy for 4 cycles of a held request, done on the 5th.
  logic [127:0] mem [64];
  int           mem_cnt = 0;
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (mem_cnt < 4);
  assign MEM_READDATA = mem[MEM_ADDRESS[5:0]];

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 64; i++) mem[i] <= blk(i);
    end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem[MEM_ADDRESS[5:0]] <= MEM_WRITEDATA;
    end
    if ((MEM_READ || MEM_WRITE) && !MEM_BUSYWAIT) mem_cnt <= 0;
    else if (MEM_READ || MEM_WRITE)                mem_cnt <= mem_cnt + 1;
    else                                           mem_cnt <= 0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    READ = rd;
    WRITE = wr;
    ADDRESS = addr;
    WRITE_DATA = wd;
  endtask

  // Runs a miss already presented on the inputs; returns at the negedge where BUSYWAIT is low.
  task automatic run_miss(output int stall, output int wb, output int fe,
                          output logic [27:0] wb_addr, output logic [27:0] fe_addr,
                          output logic [127:0] wb_data, output logic both);
    stall = 0; wb = 0; fe = 0; both = 1'b0;
    wb_addr = '0; fe_addr = '0; wb_data = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      stall++;
      if (MEM_WRITE) begin wb++; wb_addr = MEM_ADDRESS; wb_data = MEM_WRITEDATA; end
      if (MEM_READ) begin fe++; fe_addr = MEM_ADDRESS; end
      if (MEM_READ && MEM_WRITE) both = 1'b1;
      @(posedge CLK);
      #1;
    end
  endtask

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_busy;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t hits [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int st, wb, fe;
    logic [27:0] wa, fa;
    logic [127:0] wd;
    logic both;
    logic seen;

    hits[0] = '{"hit_rd_18", 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 1'b1, 32'h33333333};
    hits[1] = '{"hit_rd_28", 1'b1, 1'b0, 32'h28, 32'h0, 1'b0, 1'b1, 32'hB0000202};
    hits[2] = '{"hit_rd_1c", 1'b1, 1'b0, 32'h1C, 32'h0, 1'b0, 1'b1, 32'h44444444};
    hits[3] = '{"hit_wr_14", 1'b0, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    hits[4] = '{"hit_rd_14", 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF};
    hits[5] = '{"hit_rd_2c", 1'b1, 1'b0, 32'h2C, 32'h0, 1'b0, 1'b1, 32'hB0000203};
    hits[6] = '{"hit_rd_10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h11111111};

    RESET = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset_busywait", 128'(BUSYWAIT), 128'(0));
    check("reset_mem_read", 128'(MEM_READ), 128'(0));
    check("reset_mem_write", 128'(MEM_WRITE), 128'(0));

    // Cold read miss, 4 busy memory cycles: 1 + 5 + 1 stall cycles.
    next_cycle();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    run_miss(st, wb, fe, wa, fa, wd, both);
    check("cold_stall", 128'(st), 128'(7));
    check("cold_no_wb", 128'(wb), 128'(0));
    check("cold_fetch_cycles", 128'(fe), 128'(5));
    check("cold_fetch_addr", 128'(fa), 128'(28'h0000001));
    check("cold_read_data", 128'(READ_DATA), 128'(32'h11111111));

    next_cycle();
    drive(1'b1, 1'b0, 32'h24, 32'h0);
    run_miss(st, wb, fe, wa, fa, wd, both);
    check("idx2_stall", 128'(st), 128'(7));
    check("idx2_fetch_addr", 128'(fa), 128'(28'h0000002));
    check("idx2_read_data", 128'(READ_DATA), 128'(32'hB0000201));

    // Back-to-back hits across lines 1 and 2, including a write hit.
    next_cycle();
    for (int i = 0; i < 7; i++) begin
      drive(hits[i].rd, hits[i].wr, hits[i].addr, hits[i].wdata);
      @(negedge CLK);
      check({hits[i].name, "_busy"}, 128'(BUSYWAIT), 128'(hits[i].exp_busy));
      if (hits[i].chk_data) check({hits[i].name, "_data"}, 128'(READ_DATA), 128'(hits[i].exp_data));
      next_cycle();
    end

    // Dirty eviction of line 1 by a different tag.
    drive(1'b1, 1'b0, 32'h90, 32'h0);
    run_miss(st, wb, fe, wa, fa, wd, both);
    check("dirty_stall", 128'(st), 128'(12));
    check("dirty_wb_cycles", 128'(wb), 128'(5));
    check("dirty_wb_addr", 128'(wa), 128'(28'h0000001));
    check("dirty_wb_word1", 128'(wd[63:32]), 128'(32'hDEADBEEF));
    check("dirty_wb_word0", 128'(wd[31:0]), 128'(32'h11111111));
    check("dirty_fetch_addr", 128'(fa), 128'(28'h0000009));
    check("dirty_never_both", 128'(both), 128'(0));
    check("dirty_read_data", 128'(READ_DATA), 128'(32'hB0000900));

    // Clean eviction: straight to FETCH.
    next_cycle();
    drive(1'b1, 1'b0, 32'h110, 32'h0);
    run_miss(st, wb, fe, wa, fa, wd, both);
    check("clean_stall", 128'(st), 128'(7));
    check("clean_no_wb", 128'(wb), 128'(0));
    check("clean_fetch_addr", 128'(fa), 128'(28'h0000011));
    check("clean_read_data", 128'(READ_DATA), 128'(32'hB0001100));

    // READ and WRITE together on a hit behave as a write.
    next_cycle();
    drive(1'b1, 1'b1, 32'h114, 32'hCAFEF00D);
    @(negedge CLK);
    check("rw_busy", 128'(BUSYWAIT), 128'(0));
    next_cycle();
    drive(1'b1, 1'b0, 32'h114, 32'h0);
    @(negedge CLK);
    check("rw_busy_after", 128'(BUSYWAIT), 128'(0));
    check("rw_data", 128'(READ_DATA), 128'(32'hCAFEF00D));

    // The line written by the combined request must be written back.
    next_cycle();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    run_miss(st, wb, fe, wa, fa, wd, both);
    check("rw_evict_wb_cycles", 128'(wb), 128'(5));
    check("rw_evict_wb_addr", 128'(wa), 128'(28'h0000011));
    check("rw_evict_wb_word1", 128'(wd[63:32]), 128'(32'hCAFEF00D));
    check("rw_evict_fetch_addr", 128'(fa), 128'(28'h0000001));
    check("rw_evict_read_data", 128'(READ_DATA), 128'(32'h11111111));
    next_cycle();
    drive(1'b1, 1'b0, 32'h14, 32'h0);
    @(negedge CLK);
    check("wb_roundtrip_busy", 128'(BUSYWAIT), 128'(0));
    check("wb_roundtrip_data", 128'(READ_DATA), 128'(32'hDEADBEEF));

    // Dirty line 1, then reset in the middle of a fetch for line 2.
    next_cycle();
    drive(1'b0, 1'b1, 32'h18, 32'h12345678);
    @(negedge CLK);
    check("pre_reset_wr_busy", 128'(BUSYWAIT), 128'(0));
    next_cycle();
    drive(1'b1, 1'b0, 32'h220, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (MEM_READ) begin seen = 1'b1; break; end
    end
    check("mid_fetch_reached", 128'(seen), 128'(1));
    RESET = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    check("mid_reset_mem_read", 128'(MEM_READ), 128'(0));
    check("mid_reset_mem_write", 128'(MEM_WRITE), 128'(0));
    check("mid_reset_busy", 128'(BUSYWAIT), 128'(0));
    next_cycle();
    RESET = 1'b0;
    drive(1'b1, 1'b0, 32'h18, 32'h0);
    @(negedge CLK);
    check("post_reset_miss", 128'(BUSYWAIT), 128'(1));
    run_miss(st, wb, fe, wa, fa, wd, both);
    check("post_reset_stall", 128'(st), 128'(6));
    check("post_reset_no_wb", 128'(wb), 128'(0));
    check("post_reset_fetch_addr", 128'(fa), 128'(28'h0000001));
    check("post_reset_data", 128'(READ_DATA), 128'(32'h33333333));

    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge CLK);
    check("idle_busy", 128'(BUSYWAIT), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-back, write-allocate data cache between the RV32IM pipeline's MEM stage and main data memory. Hits finish in the requesting cycle with no stall. Misses raise BUSYWAIT to freeze the pipeline while a small FSM:

- writes back the dirty victim block, if any;
- fetches the missing 128-bit block;
- refills the line.

## Interface
Parameters:
- INDEX_BITS, 3, log2 of line count (8 lines)
- OFFSET_BITS, 2, log2 of words per block (4 × 32-bit words = 128-bit block)
- TAG_BITS, 32-INDEX_BITS-OFFSET_BITS-2, tag width (25)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high; sampled on rising edge of CLK
- READ  in  1  CPU load request
- WRITE  in  1  CPU store request
- ADDRESS  in  32  byte address; [1:0] ignored (word accesses only)
- WRITE_DATA  in  32  store data
- READ_DATA  out  32  load data, valid when READ && !BUSYWAIT
- BUSYWAIT  out  1  stall to CPU
- MEM_READ  out  1  block read request to main memory
- MEM_WRITE  out  1  block write request to main memory
- MEM_ADDRESS  out  28  block address (ADDRESS[31:4])
- MEM_WRITEDATA  out  128  victim block for write-back
- MEM_READDATA  in  128  fetched block
- MEM_BUSYWAIT  in  1  main memory busy; transfer is done on the first cycle it is low while a request is held

## Operation
Address split:
- offset = ADDRESS[3:2]
- index = ADDRESS[6:4]
- tag = ADDRESS[31:7]

Per line: valid, dirty, tag, 128-bit data.

Hit rule:
- hit = valid[index] && tag[index]==tag, evaluated combinationally.
- READ hit: READ_DATA = data[index] word at offset, combinational. BUSYWAIT stays 0.
- WRITE hit: word at offset updated on the next rising edge; dirty set to 1. BUSYWAIT stays 0.
- READ and WRITE both high: treated as WRITE. READ_DATA is don't-care.

FSM states: IDLE, WRITEBACK, FETCH, REFILL.
- IDLE
  - BUSYWAIT = (READ||WRITE) && !hit.
  - On a miss, go to WRITEBACK if the victim is valid and dirty, else FETCH.
- WRITEBACK
  - MEM_WRITE=1.
  - MEM_ADDRESS = {tag[index], index}.
  - MEM_WRITEDATA = data[index].
  - On MEM_BUSYWAIT==0, go to FETCH.
- FETCH
  - MEM_READ=1.
  - MEM_ADDRESS = ADDRESS[31:4].
  - On MEM_BUSYWAIT==0, capture MEM_READDATA and go to REFILL.
- REFILL
  - Write the captured block into the line; valid=1, dirty=0, tag=tag.
  - Go to IDLE. The held request then hits.
- BUSYWAIT is 1 in WRITEBACK, FETCH and REFILL.
- MEM_READ and MEM_WRITE are never asserted together.
- The CPU holds READ, WRITE, ADDRESS and WRITE_DATA stable while BUSYWAIT=1.
- A request dropped mid-miss does not abort the fill; the line is still refilled.

## Timing
Reset values: state IDLE; all valid=0, dirty=0; MEM_READ=0, MEM_WRITE=0; BUSYWAIT=0 with no request.

Reset mid-miss:
- Next edge returns to IDLE and invalidates all lines.
- MEM_READ and MEM_WRITE drop that cycle.
- Dirty data is discarded.

Latency:
- Hit: 0 stall cycles.
- Clean miss, with a memory that completes after N busy cycles: 1 + (N+1) + 1 stall cycles (detect, FETCH, REFILL).
- Dirty miss: adds N+1 cycles of WRITEBACK.

Other rules:
- Consecutive hits to different lines are back-to-back, one per cycle.
- Index wrap: addresses differing only in tag evict each other.

## Structure
- Shared package dcache_pkg:
  - state enum (IDLE, WRITEBACK, FETCH, REFILL);
  - field-width localparams (TAG_BITS, INDEX_BITS, OFFSET_BITS, BLOCK_BITS=128);
  - address slice helper functions.
- Sub-module dcache_array holds valid/dirty/tag/data storage, with a combinational read port and a synchronous write port. Write ports: word write-with-dirty and block refill.
- The top holds the FSM, hit logic and memory-side muxing.

## Test plan
- Cold read miss: reset, READ 0x0000_0010, memory returns 0x44444444_33333333_22222222_11111111 after 4 busy cycles.
  - Required: BUSYWAIT high for 7 cycles, MEM_ADDRESS=0x0000001, READ_DATA=0x11111111 when BUSYWAIT falls.
- Read hit: READ 0x0000_0018 after the above.
  - Required: BUSYWAIT stays 0, READ_DATA=0x33333333 the same cycle.
- Write hit then dirty eviction: WRITE 0xDEADBEEF to 0x14, then READ 0x0000_0090 (same index 1, different tag).
  - Required: WRITEBACK first, with MEM_WRITE=1, MEM_ADDRESS=0x0000001, MEM_WRITEDATA word1=0xDEADBEEF; then FETCH of 0x0000009.
- Clean eviction: READ 0x0000_0110 on a clean line at index 1.
  - Required: no MEM_WRITE; straight to FETCH.
- Reset mid-FETCH: assert RESET while MEM_READ=1.
  - Required: MEM_READ=0 and state IDLE next cycle; the previous hit address now misses.
- READ and WRITE both high on a hit: treated as a write; dirty set; no stall.
